// File: rtl/rca_4bit_adder.sv
// Registered ripple-carry adder: WIDTH full-adder cells chained from bit 0 upward,
// with sum, carry-out and signed overflow captured alongside a one-cycle valid strobe.
module rca_4bit_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] chain_sum;

    logic [WIDTH-1:0] sum_d,  sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d,  ovf_q;
    logic             valid_d, valid_q;

    // Each iteration is one full-adder cell; carry[i+1] depends only on cell i.
    always_comb begin
        carry     = '0;
        chain_sum = '0;
        carry[0]  = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            chain_sum[i] = in1[i] ^ in2[i] ^ carry[i];
            carry[i+1]   = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
        end
    end

    // Result registers only load on accepted operands, so X on idle inputs never reaches them.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (in_valid) begin
            sum_d   = chain_sum;
            cout_d  = carry[WIDTH];
            ovf_d   = carry[WIDTH] ^ carry[WIDTH-1];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_rca_4bit_adder.sv
// Bench for rca_4bit_adder: directed boundary cases, reset behaviour, an exhaustive
// sweep and a randomized valid/idle mix, all against an arithmetic reference model.
module tb_rca_4bit_adder;

    localparam int unsigned WIDTH = 4;
    localparam int MAXU = (1 << WIDTH) - 1;
    localparam int SMAX = (1 << (WIDTH - 1)) - 1;
    localparam int SMIN = -(1 << (WIDTH - 1));

    logic             clk = 1'b0;
    logic             clk_en = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_sum = 0;
    int exp_cout = 0;
    int exp_ovf = 0;

    rca_4bit_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned total for sum/cout, signed range test for overflow.
    task automatic model(input int a, input int b, input int ci);
        int total;
        int sa;
        int sb;
        int stot;
        total = a + b + ci;
        sa = (a > SMAX) ? a - (MAXU + 1) : a;
        sb = (b > SMAX) ? b - (MAXU + 1) : b;
        stot = sa + sb + ci;
        exp_sum  = total % (MAXU + 1);
        exp_cout = total / (MAXU + 1);
        exp_ovf  = (stot > SMAX || stot < SMIN) ? 1 : 0;
    endtask

    task automatic check_outputs(input string tag, input int exp_valid);
        check({tag, ".sum"},   32'(sum),       32'(exp_sum));
        check({tag, ".cout"},  32'(cout),      32'(exp_cout));
        check({tag, ".ovf"},   32'(ovf),       32'(exp_ovf));
        check({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
    endtask

    // Drive one operand set just after an edge, capture on the next edge, sample #1 later.
    task automatic apply(input string tag, input int a, input int b, input int ci);
        in1 = WIDTH'(a);
        in2 = WIDTH'(b);
        cin = ci[0];
        in_valid = 1'b1;
        model(a, b, ci);
        @(posedge clk);
        #1;
        check_outputs(tag, 1);
    endtask

    task automatic idle(input string tag, input int cycles);
        in_valid = 1'b0;
        in1 = 'x;
        in2 = 'x;
        cin = 1'bx;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            check_outputs(tag, 0);
        end
    endtask

    initial begin
        // Reset with no clock running must clear outputs immediately.
        #3 rst_n = 1'b0;
        #1;
        exp_sum = 0; exp_cout = 0; exp_ovf = 0;
        check_outputs("reset_noclk", 0);

        clk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_outputs("reset_held", 0);

        apply("5+6+0", 5, 6, 0);
        check("5+6+0.lit_sum", 32'(sum), 32'd11);
        check("5+6+0.lit_ovf", 32'(ovf), 32'd1);
        apply("12+14+0", 12, 14, 0);
        check("12+14+0.lit_sum", 32'(sum), 32'd10);
        apply("13+2+1", 13, 2, 1);
        apply("0+0+0", 0, 0, 0);
        apply("15+0+1", 15, 0, 1);
        check("15+0+1.lit_cout", 32'(cout), 32'd1);
        apply("15+15+1", 15, 15, 1);
        check("15+15+1.lit_sum", 32'(sum), 32'd15);
        idle("hold", 3);

        // Back-to-back stream, then asynchronous reset mid-stream.
        for (int k = 0; k < 4; k++) begin
            apply("b2b", int'($urandom_range(0, MAXU)), int'($urandom_range(0, MAXU)),
                  int'($urandom_range(0, 1)));
        end
        in1 = WIDTH'(9);
        in2 = WIDTH'(9);
        cin = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        exp_sum = 0; exp_cout = 0; exp_ovf = 0;
        check_outputs("reset_mid", 0);
        @(posedge clk); #1;
        check_outputs("reset_mid_held", 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle("post_reset", 3);

        // Exhaustive sweep at full rate.
        for (int a = 0; a <= MAXU; a++)
            for (int b = 0; b <= MAXU; b++)
                for (int ci = 0; ci < 2; ci++)
                    apply("sweep", a, b, ci);

        // Random mix of accepted operands and idle cycles with X inputs.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                apply("rand", int'($urandom_range(0, MAXU)), int'($urandom_range(0, MAXU)),
                      int'($urandom_range(0, 1)));
            end else begin
                idle("rand_idle", 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
